// File: rtl/sap_out_uart_tx.sv
// -----------------------------------------------------------------------------
// sap_out_uart_tx
//
// Watches the SAP-1 output register level. Each time it settles to a value
// that differs from the last one sent (or the first value after reset), the
// value is sent as three decimal ASCII digits followed by CR LF, as 8N1 UART.
//
// Parameters:
//   CLKS_PER_BIT  system clocks per UART bit (2..65535)
//
// Ports:
//   clk      system clock, all state on its rising edge
//   rst_n    asynchronous active-low reset
//   value_i  CPU output register level (asynchronous, slowly changing)
//   tx_o     UART serial out, idle high, 8N1, LSB first
//   busy_o   high from frame acceptance until the final stop bit completes
//
// Build option:
//   SAP_TX_ZERO_BLANK_EN  when defined, leading-zero hundreds/tens digits are
//                         sent as spaces (0x20). Frame timing is unchanged.
// -----------------------------------------------------------------------------
module sap_out_uart_tx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value_i,
    output logic       tx_o,
    output logic       busy_o
);

    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_CONVERT = 2'd1;
    localparam logic [1:0]  ST_SEND    = 2'd2;
    localparam logic [15:0] BIT_LAST   = 16'(CLKS_PER_BIT - 1);

    logic [1:0]  state_q,     state_d;
    logic [7:0]  samp_q,      samp_d;
    logic [7:0]  samp_dly_q,  samp_dly_d;
    logic [1:0]  samp_vld_q,  samp_vld_d;
    logic [7:0]  last_sent_q, last_sent_d;
    logic        sent_vld_q,  sent_vld_d;
    logic [7:0]  conv_q,      conv_d;
    logic [11:0] bcd_q,       bcd_d;
    logic [2:0]  step_q,      step_d;
    logic [15:0] bit_cnt_q,   bit_cnt_d;
    logic [3:0]  bit_idx_q,   bit_idx_d;
    logic [2:0]  char_idx_q,  char_idx_d;
    logic        tx_q,        tx_d;
    logic        busy_q,      busy_d;

    logic        stable;
    logic        accept;
    logic [11:0] bcd_adj;
    logic [7:0]  char_byte;
    logic [9:0]  frame_bits;

    // Double-dabble correction: every BCD nibble above 4 gets +3 before the shift.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dd_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] > 4'd4) ?
                                        (bcd_q[gi*4 +: 4] + 4'd3) :
                                        bcd_q[gi*4 +: 4];
        end
    endgenerate

    // Character being sent: hundreds, tens, ones, CR, LF.
    always_comb begin
        char_byte = 8'h0A;
        case (char_idx_q)
            3'd0:    char_byte = {4'h3, bcd_q[11:8]};
            3'd1:    char_byte = {4'h3, bcd_q[7:4]};
            3'd2:    char_byte = {4'h3, bcd_q[3:0]};
            3'd3:    char_byte = 8'h0D;
            default: char_byte = 8'h0A;
        endcase
`ifdef SAP_TX_ZERO_BLANK_EN
        if (char_idx_q == 3'd0 && bcd_q[11:8] == 4'd0) begin
            char_byte = 8'h20;
        end
        // Tens is only a leading zero when hundreds is zero as well.
        if (char_idx_q == 3'd1 && bcd_q[11:8] == 4'd0 && bcd_q[7:4] == 4'd0) begin
            char_byte = 8'h20;
        end
`endif
    end

    // Stop, data (LSB at index 1), start.
    assign frame_bits = {1'b1, char_byte, 1'b0};

    // samp_vld_q makes sure both compare registers hold real post-reset
    // samples; otherwise their cleared zeros would look like a stable 0 on
    // the first edge after reset and a spurious "000" frame would go out.
    assign stable = samp_vld_q[1] && (samp_q == samp_dly_q);
    assign accept = (state_q == ST_IDLE) && stable &&
                    (!sent_vld_q || (samp_dly_q != last_sent_q));

    always_comb begin
        state_d     = state_q;
        samp_d      = value_i;
        samp_dly_d  = samp_q;
        samp_vld_d  = {samp_vld_q[0], 1'b1};
        last_sent_d = last_sent_q;
        sent_vld_d  = sent_vld_q;
        conv_d      = conv_q;
        bcd_d       = bcd_q;
        step_d      = step_q;
        bit_cnt_d   = bit_cnt_q;
        bit_idx_d   = bit_idx_q;
        char_idx_d  = char_idx_q;
        tx_d        = 1'b1;
        // Outputs are registered one clock behind the state so the line and
        // busy flag change on the edges that begin/end each UART bit.
        busy_d      = (state_q != ST_IDLE) || accept;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    conv_d      = samp_dly_q;
                    last_sent_d = samp_dly_q;
                    sent_vld_d  = 1'b1;
                    bcd_d       = 12'd0;
                    step_d      = 3'd0;
                    state_d     = ST_CONVERT;
                end
            end

            ST_CONVERT: begin
                bcd_d  = {bcd_adj[10:0], conv_q[7]};
                conv_d = {conv_q[6:0], 1'b0};
                step_d = step_q + 3'd1;
                if (step_q == 3'd7) begin
                    bit_cnt_d  = 16'd0;
                    bit_idx_d  = 4'd0;
                    char_idx_d = 3'd0;
                    state_d    = ST_SEND;
                end
            end

            ST_SEND: begin
                tx_d = frame_bits[bit_idx_q];
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = 16'd0;
                    if (bit_idx_q == 4'd9) begin
                        bit_idx_d = 4'd0;
                        if (char_idx_q == 3'd4) begin
                            char_idx_d = 3'd0;
                            state_d    = ST_IDLE;
                        end else begin
                            char_idx_d = char_idx_q + 3'd1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            samp_q      <= 8'd0;
            samp_dly_q  <= 8'd0;
            samp_vld_q  <= 2'd0;
            last_sent_q <= 8'd0;
            sent_vld_q  <= 1'b0;
            conv_q      <= 8'd0;
            bcd_q       <= 12'd0;
            step_q      <= 3'd0;
            bit_cnt_q   <= 16'd0;
            bit_idx_q   <= 4'd0;
            char_idx_q  <= 3'd0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            samp_q      <= samp_d;
            samp_dly_q  <= samp_dly_d;
            samp_vld_q  <= samp_vld_d;
            last_sent_q <= last_sent_d;
            sent_vld_q  <= sent_vld_d;
            conv_q      <= conv_d;
            bcd_q       <= bcd_d;
            step_q      <= step_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            char_idx_q  <= char_idx_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_sap_out_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_sap_out_uart_tx
//
// Self-checking bench for sap_out_uart_tx with CLKS_PER_BIT = 4. A UART
// receiver decodes tx_o into bytes; a scoreboard of expected bytes is built
// from table constants and from a decimal-formatting reference model.
// -----------------------------------------------------------------------------
module tb_sap_out_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] value_i;
    logic       tx_o;
    logic       busy_o;

    always #5 clk = ~clk;

    sap_out_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .value_i (value_i),
        .tx_o    (tx_o),
        .busy_o  (busy_o)
    );

    int         chk_cnt   = 0;
    int         pass_cnt  = 0;
    int         frame_err = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0]  value;
        logic [39:0] bytes;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference formatter: decimal digits by plain arithmetic.
    task automatic push_frame(input logic [7:0] v);
        int h, t, o;
        logic [7:0] hc, tc, oc;
        h  = int'(v) / 100;
        t  = (int'(v) / 10) % 10;
        o  = int'(v) % 10;
        hc = 8'(8'h30 + h);
        tc = 8'(8'h30 + t);
        oc = 8'(8'h30 + o);
`ifdef SAP_TX_ZERO_BLANK_EN
        if (h == 0) hc = 8'h20;
        if (h == 0 && t == 0) tc = 8'h20;
`endif
        exp_q.push_back(hc);
        exp_q.push_back(tc);
        exp_q.push_back(oc);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic push_const(input logic [39:0] b);
        for (int i = 0; i < 5; i++) exp_q.push_back(b[39-8*i -: 8]);
    endtask

    task automatic compare_rx(input string name);
        int n;
        check({name, "_len"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_b%0d", name, i), int'(rx_q[i]), int'(exp_q[i]));
        $display("frame %s: %0d bytes received, %0d expected", name, rx_q.size(), exp_q.size());
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_bytes(input int nbytes, input int budget);
        int n = 0;
        while (rx_q.size() < nbytes && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic settle();
        int n = 0;
        repeat (20) @(negedge clk);
        while (busy_o && n < 600) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic apply(input logic [7:0] v);
        @(posedge clk);
        #1 value_i = v;
    endtask

    // UART receiver: first low sample is in the first start-bit clock; data
    // bit j is sampled 5+4j clocks later, stop at 37. Reset aborts a byte.
    initial begin
        logic [7:0] b;
        logic       ok;
        logic       stop_v;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_o === 1'b0) begin
                ok     = 1'b1;
                b      = 8'h00;
                stop_v = 1'b0;
                for (int c = 1; c <= 37; c++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        ok = 1'b0;
                        break;
                    end
                    if (c >= 5 && c <= 33 && ((c - 5) % 4) == 0) b[(c-5)/4] = tx_o;
                    if (c == 37) stop_v = tx_o;
                end
                if (ok) begin
                    rx_q.push_back(b);
                    if (stop_v !== 1'b1) frame_err++;
                end
            end
        end
    end

    logic tx_hist   [300];
    logic busy_hist [300];

    initial begin
        vec_t vecs[6];
        int   first_tx0, first_busy, busy_cnt, busy_seen;
        logic [7:0] model_last;
        logic [7:0] v;

`ifdef SAP_TX_ZERO_BLANK_EN
        vecs[0] = '{8'd255, 40'h3235350D0A};
        vecs[1] = '{8'd100, 40'h3130300D0A};
        vecs[2] = '{8'd40,  40'h2034300D0A};
        vecs[3] = '{8'd9,   40'h2020390D0A};
        vecs[4] = '{8'd233, 40'h3233330D0A};
        vecs[5] = '{8'd7,   40'h2020370D0A};
`else
        vecs[0] = '{8'd255, 40'h3235350D0A};
        vecs[1] = '{8'd100, 40'h3130300D0A};
        vecs[2] = '{8'd40,  40'h3034300D0A};
        vecs[3] = '{8'd9,   40'h3030390D0A};
        vecs[4] = '{8'd233, 40'h3233330D0A};
        vecs[5] = '{8'd7,   40'h3030370D0A};
`endif

        // Reset state, then first value 0 must be sent exactly once.
        value_i = 8'd0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", tx_o, 1);
        check("rst_busy", busy_o, 0);
        rst_n = 1'b1;
        push_frame(8'd0);
        wait_bytes(5, 400);
        repeat (300) @(negedge clk);
        compare_rx("reset_zero");

        // Value 13: latency, bit width and busy window.
        apply(8'd13);
        push_frame(8'd13);
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            @(negedge clk);
            tx_hist[k]   = tx_o;
            busy_hist[k] = busy_o;
        end
        first_tx0  = -1;
        first_busy = -1;
        busy_cnt   = 0;
        for (int k = 0; k < 300; k++) begin
            if (first_tx0 < 0 && tx_hist[k] == 1'b0) first_tx0 = k;
            if (first_busy < 0 && busy_hist[k] == 1'b1) first_busy = k;
            if (busy_hist[k] == 1'b1) busy_cnt++;
        end
        check("tx_fall_edge", first_tx0, 11);
        check("busy_rise_edge", first_busy, 2);
        check("busy_clocks", busy_cnt, 209);
        check("busy_at_211", busy_hist[211], 0);
        check("tx_start_end", tx_hist[14], 0);
        check("tx_bit3_end", tx_hist[30], 0);
        check("tx_bit5_first", tx_hist[35], 1);
        check("tx_bit5_last", tx_hist[38], 1);
        check("tx_bit6_first", tx_hist[39], 0);
        settle();
        compare_rx("v13");

        // Table of values with hand-written expected bytes.
        for (int i = 0; i < 6; i++) begin
            apply(vecs[i].value);
            push_const(vecs[i].bytes);
            wait_bytes(5, 400);
            settle();
            compare_rx($sformatf("table_%0d", vecs[i].value));
        end

        // 1, then 2 and 3 during the frame: "001" then only "003".
        apply(8'd1);
        repeat (20) @(posedge clk);
        #1 value_i = 8'd2;
        repeat (30) @(posedge clk);
        #1 value_i = 8'd3;
        push_frame(8'd1);
        push_frame(8'd3);
        wait_bytes(10, 1000);
        settle();
        repeat (200) @(negedge clk);
        compare_rx("drop_002");

        // One-clock glitch to 99 is never accepted.
        apply(8'd99);
        apply(8'd3);
        busy_seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (busy_o) busy_seen++;
        end
        check("glitch_busy", busy_seen, 0);
        compare_rx("glitch");

        // Reset during tens-digit data bits; value is re-sent from scratch.
        apply(8'd57);
        repeat (62) @(posedge clk);
        #2;
        check("pre_rst_tx", tx_o, 0);
        check("pre_rst_busy", busy_o, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx_o, 1);
        check("mid_rst_busy", busy_o, 0);
        rx_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_frame(8'd57);
        wait_bytes(5, 400);
        settle();
        compare_rx("reset_resend");

        // Randomized values against the reference model.
        model_last = 8'd57;
        for (int i = 0; i < 16; i++) begin
            v = ($urandom_range(0, 3) == 0) ? model_last : 8'($urandom_range(0, 255));
            apply(v);
            if (v != model_last) begin
                push_frame(v);
                wait_bytes(5, 400);
            end
            model_last = v;
            settle();
            compare_rx($sformatf("rand%0d_v%0d", i, v));
        end

        check("framing_errors", frame_err, 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
